// File: rtl/nmi_sram_responder_if.sv
// nmi_if: valid/ready memory-interface bundle between an initiator (user core)
// and a responder (memory target).
//   valid  initiator -> responder  request present, held until ready
//   ready  responder -> initiator  single-cycle completion pulse
//   addr   initiator -> responder  byte address
//   wdata  initiator -> responder  write data
//   wstrb  initiator -> responder  byte-lane write enables, 4'b0000 = read
//   rdata  responder -> initiator  read data, meaningful only while ready=1
interface nmi_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input ready, input rdata);
  modport slave  (input valid, input addr, input wdata, input wstrb,
                  output ready, output rdata);
endinterface

// File: rtl/nmi_sram_responder.sv
// nmi_sram_responder: word-organised scratch RAM answering nmi requests at a
// fixed base address, with programmable wait states and byte-lane writes.
// Out-of-range accesses return ERR_RDATA (reads), pulse err_o and are counted.
// Ports:
//   clk_i      system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   nmi        nmi_if.slave request/response bundle
//   err_o      one-cycle pulse alongside ready on an out-of-range access
//   err_cnt_o  saturating count of out-of-range accesses
module nmi_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  nmi_if.slave        nmi,
  output logic        err_o,
  output logic [15:0] err_cnt_o
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  // Counter preload; WAIT_CYCLES==0 never enters WAIT so the value is unused.
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               hit_q;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic [31:0]        mem [DEPTH_WORDS];

  // Address decode on the live request. Subtraction wraps, so addresses
  // below BASE_ADDR become huge offsets and miss.
  logic [31:0]        offset_s;
  logic               hit_in_s;
  logic [IDX_W-1:0]   idx_in_s;

  assign offset_s = nmi.addr - BASE_ADDR;
  assign hit_in_s = (offset_s < SPAN);
  assign idx_in_s = offset_s[IDX_W+1:2];

  // Attributes of the transaction about to enter RESP: with zero wait states
  // the response is built from the live request, otherwise from the latches.
  logic [IDX_W-1:0]   eff_idx_s;
  logic               eff_hit_s;
  logic               eff_wr_s;

  // Select live vs latched request attributes.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_idx_s = idx_in_s;
      eff_hit_s = hit_in_s;
      eff_wr_s  = (nmi.wstrb != 4'b0000);
    end else begin
      eff_idx_s = idx_q;
      eff_hit_s = hit_q;
      eff_wr_s  = (wstrb_q != 4'b0000);
    end
  end

  // FSM state and wait-counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (nmi.valid) begin
          cnt_d = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs, computed one cycle early so they appear registered in RESP.
  always_comb begin
    ready_d   = (state_d == ST_RESP);
    err_d     = 1'b0;
    rdata_d   = 32'h0000_0000;
    err_cnt_d = err_cnt_q;
    if (ready_d) begin
      err_d = ~eff_hit_s;
      if (eff_wr_s) begin
        rdata_d = 32'h0000_0000;
      end else if (eff_hit_s) begin
        rdata_d = mem[eff_idx_s];
      end else begin
        rdata_d = ERR_RDATA;
      end
      if (!eff_hit_s && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Response output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      err_q     <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Request latch, captured when IDLE accepts a request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q   <= '0;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      hit_q   <= 1'b0;
    end else if ((state_q == ST_IDLE) && nmi.valid) begin
      idx_q   <= idx_in_s;
      wdata_q <= nmi.wdata;
      wstrb_q <= nmi.wstrb;
      hit_q   <= hit_in_s;
    end
  end

  // RAM byte-lane write at the end of RESP; reset drops the FSM out of RESP,
  // which discards a pending write.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_RESP) && hit_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign nmi.ready = ready_q;
  assign nmi.rdata = rdata_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_nmi_sram_responder.sv
module tb_nmi_sram_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid_v = 4'b0000;
  logic [31:0] addr_s = 32'h0;
  logic [31:0] wdata_s = 32'h0;
  logic [3:0]  wstrb_s = 4'b0000;

  logic [3:0]  ready_w;
  logic [3:0]  err_w;
  logic [31:0] rdata_w [4];
  logic [15:0] cnt_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=1, 1: 0, 2: 3, 3: 15
  for (genvar g = 0; g < 4; g++) begin : g_dut
    nmi_if u_if ();
    assign u_if.valid  = valid_v[g];
    assign u_if.addr   = addr_s;
    assign u_if.wdata  = wdata_s;
    assign u_if.wstrb  = wstrb_s;
    assign ready_w[g]  = u_if.ready;
    assign rdata_w[g]  = u_if.rdata;
    nmi_sram_responder #(
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
    ) u_dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .nmi       (u_if.slave),
      .err_o     (err_w[g]),
      .err_cnt_o (cnt_w[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One transaction on instance k; optionally drop valid after capture.
  task automatic xfer(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit drop_early,
                      output logic [31:0] rd, output logic er,
                      output logic [15:0] cn, output int lat);
    bit got;
    @(posedge clk); #1;
    addr_s = a; wdata_s = d; wstrb_s = s; valid_v[k] = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_w[k]) begin
        got = 1'b1;
      end else begin
        lat++;
        if (drop_early && i == 0) begin
          @(posedge clk); #1;
          valid_v[k] = 1'b0;
        end
      end
    end
    if (!got) begin
      lat = -1;
      chk("ready_timeout", 32'd0, 32'd1);
    end
    rd = rdata_w[k]; er = err_w[k]; cn = cnt_w[k];
    @(posedge clk); #1;
    valid_v[k] = 1'b0; wstrb_s = 4'b0000;
    @(negedge clk);
    chk($sformatf("idle_after_i%0d", k), {ready_w[k], err_w[k], rdata_w[k]}, 34'h0);
  endtask

  // Back-to-back reads with valid held: latency to first ready, gap to second.
  task automatic btb(input int k, output int lat, output int gap);
    bit got;
    @(posedge clk); #1;
    addr_s = BASE + 32'h8; wstrb_s = 4'b0000; valid_v[k] = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_w[k]) got = 1'b1; else lat++;
    end
    if (!got) lat = -1;
    gap = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      gap++;
      if (ready_w[k]) got = 1'b1;
    end
    if (!got) gap = -1;
    @(posedge clk); #1;
    valid_v[k] = 1'b0;
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] r, logic e, logic [15:0] c);
    vec_t v;
    v.addr = a; v.wdata = d; v.wstrb = s; v.rdata = r; v.err = e; v.cnt = c;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [15:0] cn;
    int          lat, gap;
    bit          seen;
    int          exp_lat [4];
    exp_lat = '{2, 1, 4, 16};

    vecs[0]  = mk(BASE + 32'h010,  32'h1234_5678, 4'hF,    32'h0,          1'b0, 16'd0);
    vecs[1]  = mk(BASE + 32'h010,  32'h0,         4'h0,    32'h1234_5678,  1'b0, 16'd0);
    vecs[2]  = mk(BASE + 32'h010,  32'hAABB_CCDD, 4'b0101, 32'h0,          1'b0, 16'd0);
    vecs[3]  = mk(BASE + 32'h010,  32'h0,         4'h0,    32'h12BB_56DD,  1'b0, 16'd0);
    vecs[4]  = mk(BASE + 32'h013,  32'h9900_0000, 4'b1000, 32'h0,          1'b0, 16'd0);
    vecs[5]  = mk(BASE + 32'h010,  32'h0,         4'h0,    32'h99BB_56DD,  1'b0, 16'd0);
    vecs[6]  = mk(BASE + 32'h000,  32'h0000_0000, 4'hF,    32'h0,          1'b0, 16'd0);
    vecs[7]  = mk(BASE + 32'hFFC,  32'h5A5A_5A5A, 4'hF,    32'h0,          1'b0, 16'd0);
    vecs[8]  = mk(BASE + 32'h1000, 32'h0,         4'h0,    32'hDEAD_BEEF,  1'b1, 16'd1);
    vecs[9]  = mk(BASE - 32'h4,    32'h0,         4'h0,    32'hDEAD_BEEF,  1'b1, 16'd2);
    vecs[10] = mk(BASE - 32'h4,    32'hFFFF_FFFF, 4'hF,    32'h0,          1'b1, 16'd3);
    vecs[11] = mk(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF,    32'h0,          1'b1, 16'd4);
    vecs[12] = mk(BASE + 32'h000,  32'h0,         4'h0,    32'h0000_0000,  1'b0, 16'd4);
    vecs[13] = mk(BASE + 32'hFFC,  32'h0,         4'h0,    32'h5A5A_5A5A,  1'b0, 16'd4);
    vecs[14] = mk(BASE + 32'h010,  32'h0,         4'h0,    32'h99BB_56DD,  1'b0, 16'd4);
    vecs[15] = mk(BASE + 32'hFFF,  32'h0,         4'h0,    32'h5A5A_5A5A,  1'b0, 16'd4);

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, ready_w[0]}, 32'h0);
    chk("reset_rdata", rdata_w[0], 32'h0);
    chk("reset_err",   {31'h0, err_w[0]}, 32'h0);
    chk("reset_cnt",   {16'h0, cnt_w[0]}, 32'h0);
    rst_n = 1'b1;

    // Table-driven: write/read, partial writes, misses (instance 0, 1 wait state)
    for (int i = 0; i < 16; i++) begin
      xfer(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, rd, er, cn, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_cnt", i), {16'h0, cn}, {16'h0, vecs[i].cnt});
      chk($sformatf("v%0d_lat", i), lat, 32'd2);
    end

    // Saturation: preset counter to FFFE, then three misses
    @(negedge clk);
    force g_dut[0].u_dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release g_dut[0].u_dut.err_cnt_q;
    for (int i = 0; i < 3; i++) begin
      xfer(0, BASE + 32'h1000, 32'h0, 4'h0, 1'b0, rd, er, cn, lat);
      chk($sformatf("sat%0d_err", i), {31'h0, er}, 32'h1);
      chk($sformatf("sat%0d_cnt", i), {16'h0, cn}, 32'h0000_FFFF);
    end

    // Reset during WAIT of a write: no ready, word unchanged, counter cleared
    xfer(0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, rd, er, cn, lat);
    @(posedge clk); #1;
    addr_s = BASE + 32'h20; wdata_s = 32'hFFFF_FFFF; wstrb_s = 4'hF; valid_v[0] = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; valid_v[0] = 1'b0; wstrb_s = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready_w[0]) seen = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    chk("rst_no_ready", {31'h0, seen}, 32'h0);
    chk("rst_cnt", {16'h0, cnt_w[0]}, 32'h0);
    xfer(0, BASE + 32'h20, 32'h0, 4'h0, 1'b0, rd, er, cn, lat);
    chk("rst_word", rd, 32'h0);

    // Valid dropped during WAIT still completes (instance 2, 3 wait states)
    xfer(2, BASE + 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1, rd, er, cn, lat);
    chk("drop_lat", lat, 32'd4);
    xfer(2, BASE + 32'h40, 32'h0, 4'h0, 1'b0, rd, er, cn, lat);
    chk("drop_rdata", rd, 32'hCAFE_F00D);
    chk("drop_rd_lat", lat, 32'd4);

    // Zero-wait read-after-write (instance 1)
    xfer(1, BASE + 32'h44, 32'h0BAD_F00D, 4'hF, 1'b0, rd, er, cn, lat);
    xfer(1, BASE + 32'h44, 32'h0, 4'h0, 1'b0, rd, er, cn, lat);
    chk("w0_raw", rd, 32'h0BAD_F00D);

    // Latency sweep and back-to-back spacing across wait-state settings
    for (int k = 0; k < 4; k++) begin
      btb(k, lat, gap);
      chk($sformatf("btb%0d_lat", k), lat, exp_lat[k]);
      chk($sformatf("btb%0d_gap", k), gap, exp_lat[k] + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
